// File: rtl/rotary_accumulator.sv
// Rotary-wheel accumulator: detent events step a saturating value, faster spins take bigger steps,
// and every value change is offered to a consumer through a single-entry valid/ready report slot.
module rotary_accumulator #(
    parameter int WIDTH       = 8,
    parameter int MAX_VALUE   = 255,
    parameter int RESET_VALUE = 0,
    parameter int FAST_WINDOW = 2500000,
    parameter int FAST_STEP   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rotary_event,
    input  logic             rotary_left,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] value,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             saturated
);

    // state | meaning
    // IDLE  | no report outstanding, out_valid low
    // PEND  | report outstanding, out_data holds the latest changed value
    typedef enum logic {IDLE, PEND} state_t;

    localparam int GAP_W = (FAST_WINDOW > 0) ? $clog2(FAST_WINDOW + 1) : 1;
    localparam logic [GAP_W-1:0] GAP_MAX     = GAP_W'(FAST_WINDOW);
    localparam logic [WIDTH:0]   MAX_EXT     = (WIDTH+1)'(MAX_VALUE);
    localparam logic [WIDTH:0]   FAST_EXT    = (WIDTH+1)'(FAST_STEP);
    localparam logic [WIDTH-1:0] MAX_W       = WIDTH'(MAX_VALUE);
    localparam logic [WIDTH-1:0] RESET_W     = WIDTH'(RESET_VALUE);

    state_t           state;
    logic [GAP_W-1:0] gap;

    logic             event_taken;
    logic [WIDTH:0]   step;
    logic [WIDTH:0]   value_ext;
    logic [WIDTH:0]   moved;
    logic [WIDTH-1:0] load_clamped;
    logic [WIDTH-1:0] next_value;
    logic             blocked;
    logic             changed;
    logic             transfer;

    // A load in the same cycle swallows the wheel event entirely.
    assign event_taken  = rotary_event && !load;
    assign step         = (gap < GAP_MAX) ? FAST_EXT : (WIDTH+1)'(1);
    assign value_ext    = {1'b0, value};
    assign load_clamped = (load_value > MAX_W) ? MAX_W : load_value;
    assign transfer     = out_valid && out_ready;

    always_comb begin
        moved = value_ext;
        if (rotary_left) begin
            moved = (value_ext < step) ? '0 : value_ext - step;
        end else begin
            moved = value_ext + step;
            if (moved > MAX_EXT) moved = MAX_EXT;
        end
    end

    always_comb begin
        next_value = value;
        if (load)
            next_value = load_clamped;
        else if (event_taken)
            next_value = moved[WIDTH-1:0];
    end

    assign blocked = event_taken && (rotary_left ? (value == '0) : (value == MAX_W));
    assign changed = (next_value != value);

    always_ff @(posedge clk) begin
        if (rst) begin
            value     <= RESET_W;
            out_data  <= RESET_W;
            state     <= IDLE;
            out_valid <= 1'b0;
            saturated <= 1'b0;
            gap       <= GAP_MAX;
        end else begin
            value     <= next_value;
            saturated <= blocked;

            if (event_taken)
                gap <= '0;
            else if (gap < GAP_MAX)
                gap <= gap + 1'b1;

            case (state)
                IDLE: begin
                    if (changed) begin
                        state     <= PEND;
                        out_valid <= 1'b1;
                        out_data  <= next_value;
                    end
                end
                PEND: begin
                    // A fresh change always wins over retiring the current report.
                    if (changed) begin
                        out_data <= next_value;
                    end else if (transfer) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rotary_accumulator.sv
// Bench for rotary_accumulator: directed scenarios plus randomized traffic checked
// against an integer-arithmetic model of the wheel, clamping and report slot.
module tb_rotary_accumulator;

    localparam int WIDTH = 4;
    localparam int MAXV  = 12;
    localparam int RSTV  = 5;
    localparam int FW    = 8;
    localparam int FS    = 3;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             rotary_event = 1'b0;
    logic             rotary_left = 1'b0;
    logic             load = 1'b0;
    logic [WIDTH-1:0] load_value = '0;
    logic [WIDTH-1:0] value;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] out_data;
    logic             saturated;

    int n_checks = 0;
    int n_fail   = 0;

    // model state
    int m_value = RSTV;
    int m_data  = RSTV;
    int m_valid = 0;
    int m_sat   = 0;
    int m_gap   = FW;
    int m_xfers = 0;

    rotary_accumulator #(
        .WIDTH(WIDTH), .MAX_VALUE(MAXV), .RESET_VALUE(RSTV),
        .FAST_WINDOW(FW), .FAST_STEP(FS)
    ) dut (
        .clk(clk), .rst(rst), .rotary_event(rotary_event), .rotary_left(rotary_left),
        .load(load), .load_value(load_value), .value(value), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .saturated(saturated)
    );

    always #5 clk = ~clk;

    task automatic model_tick(input bit r, input bit ev, input bit lf, input bit ld,
                              input int lv, input bit rdy);
        int nv;
        int st;
        bit sat;
        if (r) begin
            m_value = RSTV; m_data = RSTV; m_valid = 0; m_sat = 0; m_gap = FW;
            return;
        end
        nv  = m_value;
        sat = 0;
        if (m_valid != 0 && rdy) m_xfers++;
        if (ld) begin
            nv = (lv > MAXV) ? MAXV : lv;
            if (m_gap < FW) m_gap++;
        end else if (ev) begin
            st = (m_gap < FW) ? FS : 1;
            nv = lf ? m_value - st : m_value + st;
            if (nv < 0) nv = 0;
            if (nv > MAXV) nv = MAXV;
            sat = (nv == m_value);
            m_gap = 0;
        end else if (m_gap < FW) begin
            m_gap++;
        end
        m_sat = sat;
        if (nv != m_value) begin
            m_valid = 1;
            m_data  = nv;
        end else if (m_valid != 0 && rdy) begin
            m_valid = 0;
        end
        m_value = nv;
    endtask

    // Drive one cycle of inputs, clock it, advance the model, settle past the edge.
    task automatic step(input bit r, input bit ev, input bit lf, input bit ld,
                        input int lv, input bit rdy);
        @(negedge clk);
        rst = r; rotary_event = ev; rotary_left = lf; load = ld;
        load_value = WIDTH'(lv); out_ready = rdy;
        @(posedge clk);
        model_tick(r, ev, lf, ld, lv, rdy);
        #1;
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, rdy);
    endtask

    task automatic test_reset;
        step(1, 1, 0, 1, 9, 1);
        n_checks++; if (value !== 4'd5) begin n_fail++; $display("FAIL reset_value got=%0d exp=5", value); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%0b exp=0", out_valid); end
        n_checks++; if (out_data !== 4'd5) begin n_fail++; $display("FAIL reset_data got=%0d exp=5", out_data); end
        n_checks++; if (saturated !== 1'b0) begin n_fail++; $display("FAIL reset_sat got=%0b exp=0", saturated); end
        step(0, 0, 0, 0, 0, 1);
    endtask

    task automatic test_single_right;
        step(0, 1, 0, 0, 0, 1);
        n_checks++; if (value !== 4'd6) begin n_fail++; $display("FAIL single_value got=%0d exp=6", value); end
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid got=%0b exp=1", out_valid); end
        n_checks++; if (out_data !== 4'd6) begin n_fail++; $display("FAIL single_data got=%0d exp=6", out_data); end
        step(0, 0, 0, 0, 0, 1);
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL single_valid_drop got=%0b exp=0", out_valid); end
    endtask

    task automatic test_fast_clamp;
        int exp_v[3] = '{7, 10, 12};
        idle(10, 1);
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 0, 0, 0, 1);
            n_checks++; if (value !== WIDTH'(exp_v[i])) begin n_fail++; $display("FAIL fast_value[%0d] got=%0d exp=%0d", i, value, exp_v[i]); end
            n_checks++; if (out_data !== WIDTH'(exp_v[i]) || out_valid !== 1'b1) begin n_fail++; $display("FAIL fast_report[%0d] got=%0d/%0b exp=%0d/1", i, out_data, out_valid, exp_v[i]); end
            idle(2, 1);
        end
        step(0, 1, 0, 0, 0, 1);
        n_checks++; if (saturated !== 1'b1) begin n_fail++; $display("FAIL sat_pulse got=%0b exp=1", saturated); end
        n_checks++; if (out_valid !== 1'b0 || value !== 4'd12) begin n_fail++; $display("FAIL sat_noreport got=%0b/%0d exp=0/12", out_valid, value); end
        step(0, 0, 0, 0, 0, 1);
        n_checks++; if (saturated !== 1'b0) begin n_fail++; $display("FAIL sat_single got=%0b exp=0", saturated); end
    endtask

    task automatic test_latest_wins;
        int x0;
        step(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            idle(10, 0);
            step(0, 1, 1, 0, 0, 0);
            n_checks++; if (out_valid !== 1'b1 || out_data !== WIDTH'(4 - i)) begin n_fail++; $display("FAIL hold[%0d] got=%0b/%0d exp=1/%0d", i, out_valid, out_data, 4 - i); end
        end
        idle(3, 0);
        n_checks++; if (out_valid !== 1'b1 || out_data !== 4'd2) begin n_fail++; $display("FAIL hold_stable got=%0b/%0d exp=1/2", out_valid, out_data); end
        x0 = m_xfers;
        step(0, 0, 0, 0, 0, 1);
        idle(3, 1);
        n_checks++; if (m_xfers - x0 != 1 || out_valid !== 1'b0) begin n_fail++; $display("FAIL one_transfer got=%0d/%0b exp=1/0", m_xfers - x0, out_valid); end
    endtask

    task automatic test_load_priority;
        step(1, 0, 0, 0, 0, 0);
        idle(2, 0);
        step(0, 1, 0, 1, 15, 0);
        n_checks++; if (value !== 4'd12) begin n_fail++; $display("FAIL load_value got=%0d exp=12", value); end
        n_checks++; if (out_valid !== 1'b1 || out_data !== 4'd12) begin n_fail++; $display("FAIL load_report got=%0b/%0d exp=1/12", out_valid, out_data); end
        step(0, 0, 0, 0, 0, 1);
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL load_xfer got=%0b exp=0", out_valid); end
        step(0, 0, 0, 1, 14, 0);
        n_checks++; if (out_valid !== 1'b0 || value !== 4'd12) begin n_fail++; $display("FAIL load_same got=%0b/%0d exp=0/12", out_valid, value); end
        // gap was never cleared by the dropped event, so the next event is slow
        step(0, 1, 1, 0, 0, 0);
        n_checks++; if (value !== 4'd11) begin n_fail++; $display("FAIL load_gap got=%0d exp=11", value); end
    endtask

    task automatic test_back_to_back;
        step(1, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0);
        n_checks++; if (out_valid !== 1'b1 || out_data !== 4'd6) begin n_fail++; $display("FAIL b2b_first got=%0b/%0d exp=1/6", out_valid, out_data); end
        step(0, 1, 0, 0, 0, 1);
        n_checks++; if (out_valid !== 1'b1 || out_data !== 4'd9) begin n_fail++; $display("FAIL b2b_second got=%0b/%0d exp=1/9", out_valid, out_data); end
        step(0, 0, 0, 0, 0, 1);
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_drain got=%0b exp=0", out_valid); end
    endtask

    task automatic test_reset_pending;
        step(0, 1, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0);
        n_checks++; if (value !== 4'd5 || out_valid !== 1'b0 || saturated !== 1'b0) begin n_fail++; $display("FAIL rst_pend got=%0d/%0b/%0b exp=5/0/0", value, out_valid, saturated); end
        step(0, 0, 0, 0, 0, 0);
        n_checks++; if (out_valid !== 1'b0 || saturated !== 1'b0) begin n_fail++; $display("FAIL rst_pend_after got=%0b/%0b exp=0/0", out_valid, saturated); end
    endtask

    task automatic test_random;
        bit r, ev, lf, ld, rdy;
        int lv;
        step(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 600; i++) begin
            r   = ($urandom_range(0, 99) < 2);
            ev  = ($urandom_range(0, 99) < 40);
            lf  = ((i / 60) % 2 == 1) ? ($urandom_range(0, 9) < 8) : ($urandom_range(0, 9) < 2);
            ld  = ($urandom_range(0, 99) < 6);
            lv  = $urandom_range(0, 15);
            rdy = ($urandom_range(0, 99) < 50);
            step(r, ev, lf, ld, lv, rdy);
            if (ev && ($urandom_range(0, 3) == 0)) idle($urandom_range(1, 10), rdy);
            n_checks++; if (value !== WIDTH'(m_value)) begin n_fail++; $display("FAIL rnd_value[%0d] got=%0d exp=%0d", i, value, m_value); end
            n_checks++; if (out_valid !== m_valid[0]) begin n_fail++; $display("FAIL rnd_valid[%0d] got=%0b exp=%0d", i, out_valid, m_valid); end
            n_checks++; if (out_valid && out_data !== WIDTH'(m_data)) begin n_fail++; $display("FAIL rnd_data[%0d] got=%0d exp=%0d", i, out_data, m_data); end
            n_checks++; if (saturated !== m_sat[0]) begin n_fail++; $display("FAIL rnd_sat[%0d] got=%0b exp=%0d", i, saturated, m_sat); end
        end
    endtask

    initial begin
        test_reset;
        test_single_right;
        test_fast_clamp;
        test_latest_wins;
        test_load_priority;
        test_back_to_back;
        test_reset_pending;
        test_random;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rotary_accumulator.md
ROTARY_ACCUMULATOR -- requirements
Module: rotary_accumulator

Interface
REQ-001 SHALL have parameter WIDTH, default 8; bit width of the accumulated value.
REQ-002 SHALL have parameter MAX_VALUE, default 255; upper saturation bound, which SHALL be less than 2^WIDTH.
REQ-003 SHALL have parameter RESET_VALUE, default 0; value loaded on reset, which SHALL be at most MAX_VALUE.
REQ-004 SHALL have parameter FAST_WINDOW, default 2500000; an event within this many cycles of the previous event counts as fast.
REQ-005 SHALL have parameter FAST_STEP, default 4; step size applied to a fast event.
REQ-006 SHALL have port clk, input, 1 bit; the single clock, with all logic on its rising edge.
REQ-007 SHALL have port rst, input, 1 bit; synchronous, active-high reset.
REQ-008 SHALL have port rotary_event, input, 1 bit; single-cycle pulse per detent from the wheel decoder.
REQ-009 SHALL have port rotary_left, input, 1 bit; valid with rotary_event, 1 = left (decrement), 0 = right (increment).
REQ-010 SHALL have port load, input, 1 bit; single-cycle request to overwrite the value.
REQ-011 SHALL have port load_value, input, WIDTH bits; value to load, clamped to MAX_VALUE.
REQ-012 SHALL have port value, output, WIDTH bits; current accumulated value, registered.
REQ-013 SHALL have port out_valid, output, 1 bit; a change report is pending.
REQ-014 SHALL have port out_ready, input, 1 bit; the consumer accepts the report.
REQ-015 SHALL have port out_data, output, WIDTH bits; value snapshot of the pending report.
REQ-016 SHALL have port saturated, output, 1 bit; single-cycle pulse when an event is blocked at a bound.

Function
REQ-017 An event with rotary_left=1 SHALL subtract the step and one with rotary_left=0 SHALL add it; the result SHALL be visible on value the cycle after the event.
REQ-018 Gap counter: SHALL count cycles since the last accepted event, saturate at FAST_WINDOW, clear to 0 on each event, and start saturated after reset.
REQ-019 The step SHALL be FAST_STEP when the gap counter is below FAST_WINDOW at the event cycle, else 1.
REQ-020 Arithmetic SHALL be done at WIDTH+1 bits and clamped to [0, MAX_VALUE]; there SHALL be no wrap-around.
REQ-021 An event that cannot move the value (value=0 with left, or value=MAX_VALUE with right) SHALL pulse saturated for one cycle and SHALL create no report.
REQ-022 A partial move at a bound SHALL clamp, report the change, and not pulse saturated.
REQ-023 load SHALL take priority over a simultaneous rotary_event; the event is dropped and the gap counter is unaffected.
REQ-024 load SHALL create a report only if the clamped load value differs from the current value.
REQ-025 Report FSM SHALL have two states:
  - IDLE: out_valid=0.
  - PEND: out_valid=1.
REQ-026 Any value change SHALL enter or stay in PEND the next cycle with out_data equal to the new value.
REQ-027 A transfer occurs when out_valid and out_ready are both high in a cycle; after a transfer the FSM SHALL go to IDLE unless a change happens in the same cycle, in which case it SHALL stay in PEND with the new snapshot.
REQ-028 While in PEND without a transfer, new changes SHALL overwrite out_data (latest wins); out_data SHALL otherwise stay stable while out_valid is high.
REQ-029 out_valid SHALL NOT depend combinationally on out_ready.

Reset
REQ-030 On rst, the block SHALL set value=RESET_VALUE, out_data=RESET_VALUE, the FSM to IDLE, out_valid=0, saturated=0 and the gap counter=FAST_WINDOW.
REQ-031 rst SHALL override load and rotary_event in the same cycle.
REQ-032 rst SHALL abort a pending report.
REQ-033 Inputs SHALL have no effect during rst.

Verification (WIDTH=4, MAX_VALUE=12, RESET_VALUE=5, FAST_WINDOW=8, FAST_STEP=3)
REQ-034 SHALL cover: reset, then one right event with out_ready=1 -> value=6 next cycle, out_valid=1 for one cycle, out_data=6.
REQ-035 SHALL cover: right events 3 cycles apart from value 6 -> 7, then 10, then 12 (clamped), then a saturated pulse with no report.
REQ-036 SHALL cover: out_ready=0 and three slow left events from 5 -> out_valid held, out_data=2 (latest wins), one transfer when out_ready rises.
REQ-037 SHALL cover: load=1 with load_value=15 and rotary_event=1 in the same cycle -> value=12, event ignored, one report.
REQ-038 SHALL cover: a change in the same cycle as a transfer -> out_valid stays 1 with the new out_data.
REQ-039 SHALL cover: rst asserted while in PEND with rotary_event=1 -> value=5, out_valid=0, no saturated pulse.
